iq_capture_buffer: RTL and testbench

//   Parametrised on-chip capture of the FSK modulator I/Q sample stream, with a pre-trigger window.

---
 rtl/iq_capture_buffer.sv | 226 ++++++++++++++++++++++
 tb/tb_iq_capture_buffer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iq_capture_buffer.sv
// iq_capture_buffer: records a pre/post-trigger window of I/Q pairs into block RAM
// and streams the window back out in capture order over a valid/ready port.
module iq_capture_buffer #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 1024,
  parameter int PRE_TRIG = 16,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              abort,
  input  logic              trig,
  input  logic [AW:0]       cap_len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_i,
  input  logic [DATA_W-1:0] in_q,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_i,
  output logic [DATA_W-1:0] rd_q,
  output logic              rd_last,
  output logic              busy,
  output logic              done,
  output logic [AW:0]       rd_count
);

  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0]   PRE_L   = (AW+1)'(PRE_TRIG);
  localparam logic [AW:0]   ONE_L   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, READOUT} state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       wrPtr_q, wrPtr_d;
  logic [AW-1:0]       rdAddr_q, rdAddr_d;
  logic [AW:0]         preCnt_q, preCnt_d;
  logic [AW:0]         postCnt_q, postCnt_d;
  logic [AW:0]         postLen_q, postLen_d;
  logic [AW:0]         rdCount_q, rdCount_d;
  logic [AW:0]         issued_q, issued_d;
  logic                ramVld_q, ramVld_d;
  logic                ramLast_q, ramLast_d;
  logic                rdValid_q, rdValid_d;
  logic                rdLast_q, rdLast_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   rdI_q, rdI_d;
  logic [DATA_W-1:0]   rdQ_q, rdQ_d;
  logic [2*DATA_W-1:0] mem [DEPTH];
  logic [2*DATA_W-1:0] ramData_q;
  logic                memWe, ramRe, advance, lastHs;
  logic [AW:0]         capLenClamped, postLenCalc;

  always_comb begin
    capLenClamped = (cap_len == '0 || cap_len > DEPTH_L) ? DEPTH_L : cap_len;
    postLenCalc   = (capLenClamped > PRE_L) ? capLenClamped - PRE_L : ONE_L;
  end

  always_comb begin
    state_d   = state_q;
    wrPtr_d   = wrPtr_q;
    rdAddr_d  = rdAddr_q;
    preCnt_d  = preCnt_q;
    postCnt_d = postCnt_q;
    postLen_d = postLen_q;
    rdCount_d = rdCount_q;
    issued_d  = issued_q;
    ramVld_d  = ramVld_q;
    ramLast_d = ramLast_q;
    rdValid_d = rdValid_q;
    rdLast_d  = rdLast_q;
    rdI_d     = rdI_q;
    rdQ_d     = rdQ_q;
    done_d    = 1'b0;
    memWe     = 1'b0;
    ramRe     = 1'b0;
    advance   = !rdValid_q || rd_ready;
    lastHs    = rdValid_q && rd_ready && rdLast_q;

    case (state_q)
      IDLE: begin
        if (arm) begin
          state_d   = ARMED;
          postLen_d = postLenCalc;
          preCnt_d  = '0;
          postCnt_d = '0;
          issued_d  = '0;
        end
      end
      ARMED: begin
        if (in_valid) begin
          memWe   = 1'b1;
          wrPtr_d = wrPtr_q + PTR_ONE;
          if (trig) begin
            // The trigger sample itself is the first post-trigger sample.
            rdAddr_d  = wrPtr_q - preCnt_q[AW-1:0];
            postCnt_d = ONE_L;
            if (postLen_q == ONE_L) begin
              state_d   = READOUT;
              rdCount_d = preCnt_q + postLen_q;
            end else begin
              state_d = CAPTURE;
            end
          end else if (preCnt_q != PRE_L) begin
            preCnt_d = preCnt_q + ONE_L;
          end
        end
      end
      CAPTURE: begin
        if (in_valid) begin
          memWe     = 1'b1;
          wrPtr_d   = wrPtr_q + PTR_ONE;
          postCnt_d = postCnt_q + ONE_L;
          if (postCnt_q + ONE_L == postLen_q) begin
            state_d   = READOUT;
            rdCount_d = preCnt_q + postLen_q;
          end
        end
      end
      READOUT: begin
        // Two-stage stall pipeline: RAM data register feeds the output register.
        if (advance) begin
          rdValid_d = ramVld_q;
          rdLast_d  = ramVld_q && ramLast_q;
          if (ramVld_q) begin
            rdI_d = ramData_q[2*DATA_W-1:DATA_W];
            rdQ_d = ramData_q[DATA_W-1:0];
          end
        end
        if (!ramVld_q || advance) begin
          if (issued_q != rdCount_q) begin
            ramRe     = 1'b1;
            ramVld_d  = 1'b1;
            ramLast_d = (issued_q + ONE_L) == rdCount_q;
            rdAddr_d  = rdAddr_q + PTR_ONE;
            issued_d  = issued_q + ONE_L;
          end else begin
            ramVld_d  = 1'b0;
            ramLast_d = 1'b0;
          end
        end
        if (lastHs) begin
          state_d   = IDLE;
          done_d    = 1'b1;
          rdValid_d = 1'b0;
          rdLast_d  = 1'b0;
          ramVld_d  = 1'b0;
          ramLast_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d   = IDLE;
      wrPtr_d   = '0;
      rdAddr_d  = '0;
      preCnt_d  = '0;
      postCnt_d = '0;
      rdCount_d = '0;
      issued_d  = '0;
      ramVld_d  = 1'b0;
      ramLast_d = 1'b0;
      rdValid_d = 1'b0;
      rdLast_d  = 1'b0;
      done_d    = 1'b0;
      memWe     = 1'b0;
      ramRe     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (memWe && !rst) begin
      mem[wrPtr_q] <= {in_i, in_q};
    end
    if (ramRe && !rst) begin
      ramData_q <= mem[rdAddr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wrPtr_q   <= '0;
      rdAddr_q  <= '0;
      preCnt_q  <= '0;
      postCnt_q <= '0;
      postLen_q <= '0;
      rdCount_q <= '0;
      issued_q  <= '0;
      ramVld_q  <= 1'b0;
      ramLast_q <= 1'b0;
      rdValid_q <= 1'b0;
      rdLast_q  <= 1'b0;
      done_q    <= 1'b0;
      rdI_q     <= '0;
      rdQ_q     <= '0;
    end else begin
      state_q   <= state_d;
      wrPtr_q   <= wrPtr_d;
      rdAddr_q  <= rdAddr_d;
      preCnt_q  <= preCnt_d;
      postCnt_q <= postCnt_d;
      postLen_q <= postLen_d;
      rdCount_q <= rdCount_d;
      issued_q  <= issued_d;
      ramVld_q  <= ramVld_d;
      ramLast_q <= ramLast_d;
      rdValid_q <= rdValid_d;
      rdLast_q  <= rdLast_d;
      done_q    <= done_d;
      rdI_q     <= rdI_d;
      rdQ_q     <= rdQ_d;
    end
  end

  assign rd_valid = rdValid_q;
  assign rd_i     = rdI_q;
  assign rd_q     = rdQ_q;
  assign rd_last  = rdLast_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign rd_count = rdCount_q;

endmodule

// File: tb/tb_iq_capture_buffer.sv
// tb_iq_capture_buffer: queue-based model of the capture window checked against the
// streamed readout, plus table-driven control and length vectors.
module tb_iq_capture_buffer;

  localparam int DATA_W   = 8;
  localparam int DEPTH    = 1024;
  localparam int PRE_TRIG = 16;
  localparam int AW       = 10;

  logic              clk = 1'b0;
  logic              rst, arm, abort, trig, in_valid, rd_ready;
  logic [AW:0]       cap_len;
  logic [DATA_W-1:0] in_i, in_q;
  logic              rd_valid, rd_last, busy, done;
  logic [DATA_W-1:0] rd_i, rd_q;
  logic [AW:0]       rd_count;

  int assertCount = 0;
  int failCount   = 0;

  typedef enum {M_IDLE, M_ARMED, M_CAPTURE, M_READOUT} mPhase_e;
  mPhase_e     mPhase = M_IDLE;
  int          mPostLen = 0;
  int          mPostCnt = 0;
  logic [15:0] preQ[$];
  logic [15:0] sb[$];

  typedef struct { logic a; logic ab; logic v; logic t; logic expBusy; } ctrlVec_t;
  typedef struct { int capLen; int nPre; int expCount; } lenVec_t;
  ctrlVec_t ctrlTab[9];
  lenVec_t  lenTab[5];

  iq_capture_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PRE_TRIG(PRE_TRIG)) dut (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort), .trig(trig), .cap_len(cap_len),
    .in_valid(in_valid), .in_i(in_i), .in_q(in_q), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_i(rd_i), .rd_q(rd_q), .rd_last(rd_last),
    .busy(busy), .done(done), .rd_count(rd_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int postLenOf(input int len);
    int l;
    l = (len == 0 || len > DEPTH) ? DEPTH : len;
    return (l > PRE_TRIG) ? l - PRE_TRIG : 1;
  endfunction

  task automatic modelStep(input logic a, input logic ab, input logic v, input logic t,
                           input logic [7:0] di, input logic [7:0] dq);
    if (ab) begin
      mPhase = M_IDLE;
      preQ.delete();
      sb.delete();
    end else begin
      case (mPhase)
        M_IDLE: if (a) begin
          mPhase   = M_ARMED;
          mPostLen = postLenOf(int'(cap_len));
          mPostCnt = 0;
          preQ.delete();
          sb.delete();
        end
        M_ARMED: if (v) begin
          if (t) begin
            foreach (preQ[k]) sb.push_back(preQ[k]);
            sb.push_back({di, dq});
            mPostCnt = 1;
            mPhase   = (mPostLen == 1) ? M_READOUT : M_CAPTURE;
          end else begin
            preQ.push_back({di, dq});
            if (preQ.size() > PRE_TRIG) void'(preQ.pop_front());
          end
        end
        M_CAPTURE: if (v) begin
          sb.push_back({di, dq});
          mPostCnt++;
          if (mPostCnt == mPostLen) mPhase = M_READOUT;
        end
        default: ;
      endcase
    end
  endtask

  task automatic applyStimulus(input logic a, input logic ab, input logic v, input logic t,
                               input logic [7:0] di, input logic [7:0] dq);
    arm = a; abort = ab; in_valid = v; trig = t; in_i = di; in_q = dq;
    modelStep(a, ab, v, t, di, dq);
    tick();
    arm = 1'b0; abort = 1'b0; in_valid = 1'b0; trig = 1'b0;
  endtask

  // Arm, send nPre pre-trigger samples, trigger, then feed samples until the window closes.
  task automatic startCapture(input int capLen, input int nPre);
    int g = 0;
    cap_len = 11'(capLen);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int n = 0; n < nPre; n++)
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'($urandom()), 8'($urandom()));
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'($urandom()), 8'($urandom()));
    while (mPhase == M_CAPTURE && g < 4 * DEPTH) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'($urandom()), 8'($urandom()), 8'($urandom()));
      g++;
    end
  endtask

  // Called right after the edge that enters READOUT; mode 1 drives rd_ready as 1,0,0,1.
  task automatic drainReadout(input int mode, input int expCount);
    int          k = 0;
    int          firstValid = -1;
    logic        stalled = 1'b0;
    logic [17:0] held = '0;
    logic [15:0] exp;
    bit          finished = 1'b0;
    checkOutput("rd_count", 32'(rd_count), 32'(expCount));
    while (!finished && k < 4 * expCount + 20) begin
      rd_ready = (mode == 0) || (k % 4 == 0) || (k % 4 == 3);
      if (rd_valid && firstValid < 0) firstValid = k;
      if (stalled) checkOutput("stall_hold", 32'({rd_valid, rd_i, rd_q, rd_last}), 32'(held));
      if (rd_valid && rd_ready && sb.size() > 0) begin
        exp = sb.pop_front();
        checkOutput("rd_data", 32'({rd_i, rd_q, rd_last}), 32'({exp, sb.size() == 0}));
        finished = (sb.size() == 0);
      end
      stalled = rd_valid && !rd_ready;
      held    = {rd_valid, rd_i, rd_q, rd_last};
      tick();
      k++;
    end
    rd_ready = 1'b0;
    checkOutput("readout_left", 32'(sb.size()), 32'd0);
    checkOutput("first_valid_lat", 32'(firstValid), 32'd2);
    checkOutput("done_busy", 32'({done, busy}), 32'b10);
    tick();
    checkOutput("done_clear", 32'(done), 32'd0);
    if (!finished) begin
      sb.delete();
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    end
    mPhase = M_IDLE;
  endtask

  initial begin
    ctrlTab[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    ctrlTab[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    ctrlTab[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    ctrlTab[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    ctrlTab[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    ctrlTab[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    ctrlTab[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    ctrlTab[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    ctrlTab[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    lenTab[0]  = '{1,    0,  1};
    lenTab[1]  = '{16,   20, 17};
    lenTab[2]  = '{17,   2,  3};
    lenTab[3]  = '{20,   10, 14};
    lenTab[4]  = '{2000, 3,  1011};

    rst = 1'b1; arm = 1'b0; abort = 1'b0; trig = 1'b0; in_valid = 1'b0; rd_ready = 1'b0;
    cap_len = '0; in_i = '0; in_q = '0;
    repeat (3) tick();
    checkOutput("reset_flags", 32'({rd_valid, rd_last, busy, done}), 32'd0);
    checkOutput("reset_data", 32'({rd_i, rd_q}), 32'd0);
    checkOutput("reset_count", 32'(rd_count), 32'd0);
    rst = 1'b0;
    tick();

    $display("[TB] control vectors");
    cap_len = 11'd40;
    for (int r = 0; r < 9; r++) begin
      applyStimulus(ctrlTab[r].a, ctrlTab[r].ab, ctrlTab[r].v, ctrlTab[r].t, 8'($urandom()), 8'($urandom()));
      checkOutput($sformatf("ctrl_busy_%0d", r), 32'(busy), 32'(ctrlTab[r].expBusy));
      checkOutput($sformatf("ctrl_idle_out_%0d", r), 32'({rd_valid, done}), 32'd0);
    end

    $display("[TB] length vectors");
    for (int r = 0; r < 5; r++) begin
      startCapture(lenTab[r].capLen, lenTab[r].nPre);
      drainReadout(0, lenTab[r].expCount);
    end

    $display("[TB] ramp capture, cap_len 970, trigger at n=20");
    cap_len = 11'd970;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int n = 0; n < 2000 && mPhase != M_READOUT; n++)
      applyStimulus(1'b0, 1'b0, 1'b1, 1'(n == 20), 8'(n), 8'(-n));
    drainReadout(0, 970);

    $display("[TB] early trigger: five pre samples then trigger");
    cap_len = 11'd40;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int n = 1; n < 200 && mPhase != M_READOUT; n++)
      applyStimulus(1'b0, 1'b0, 1'b1, 1'(n == 6), 8'(n), 8'(n + 64));
    drainReadout(0, 29);

    $display("[TB] backpressure");
    startCapture(30, 8);
    drainReadout(1, 22);

    $display("[TB] sparse in_valid during capture");
    cap_len = 11'd24;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int n = 0; n < 4; n++)
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'(10 + n), 8'(20 + n));
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h50, 8'h60);
    for (int c = 0; c < 200 && mPhase == M_CAPTURE; c++) begin
      if (c % 3 == 2) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'(100 + c), 8'(c));
      else            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'hEE, 8'hEE);
    end
    drainReadout(0, 12);

    $display("[TB] abort mid-capture then full-depth capture");
    cap_len = 11'd40;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int n = 0; n < 10; n++)
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'($urandom()), 8'($urandom()));
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 8'h22);
    for (int n = 0; n < 3; n++)
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'($urandom()), 8'($urandom()));
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    checkOutput("abort_state", 32'({busy, rd_valid, done}), 32'd0);
    tick();
    checkOutput("abort_no_done", 32'(done), 32'd0);
    startCapture(0, 30);
    drainReadout(0, 1024);

    $display("[TB] reset during readout");
    startCapture(20, 5);
    rd_ready = 1'b0;
    repeat (3) tick();
    checkOutput("stalled_valid", 32'(rd_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    mPhase = M_IDLE;
    checkOutput("rst_flags", 32'({rd_valid, rd_last, busy, done}), 32'd0);
    checkOutput("rst_data", 32'({rd_i, rd_q}), 32'd0);
    checkOutput("rst_count", 32'(rd_count), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    checkOutput("arm_abort_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
